// File: rtl/packet_send_scheduler.sv
// Packet send scheduler: arbitrates periodic and manual send rounds
// between two send_packet channels with fixed pulse and gap timing.
module packet_send_scheduler #(
  parameter logic [31:0] PERIOD    = 32'h000000ff,
  parameter int          PULSE_LEN = 3,
  parameter int          GAP_LEN   = 8
) (
  input  logic        clk_50,
  input  logic        rst_n,
  input  logic        mac_inited,
  input  logic        rx_ready,
  input  logic        auto_en,
  input  logic        req_1,
  input  logic        req_2,
  input  logic [24:0] addr_1,
  input  logic [24:0] addr_2,
  output logic [24:0] start_ram_addr_1,
  output logic [24:0] start_ram_addr_2,
  output logic        cmd_send_1,
  output logic        cmd_send_2,
  output logic        busy,
  output logic [15:0] sent_cnt_1,
  output logic [15:0] sent_cnt_2
);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    GAP
  } state_t;

  state_t      state_q;
  logic [31:0] timer_q;
  logic [15:0] phase_q;
  logic        pend1_q, pend2_q;
  logic        last2_q;
  logic        gch2_q;
  logic        cmd1_q, cmd2_q;
  logic        busy_q;
  logic [24:0] addr1_q, addr2_q;
  logic [15:0] cnt1_q, cnt2_q;

  logic        ready;
  logic        tick;
  logic        fire;
  logic        grant;
  logic        grant2;
  logic        pend1_d, pend2_d;

  assign ready  = mac_inited & rx_ready;
  assign tick   = ready & auto_en;
  assign fire   = tick & (timer_q == PERIOD - 32'd1);
  assign grant  = (state_q == IDLE) & ready
                & (pend1_q | pend2_q);
  // Both pending: alternate away from the last grant.
  assign grant2 = pend2_q & (~pend1_q | ~last2_q);

  assign pend1_d = (pend1_q & ~(grant & ~grant2))
                 | req_1 | fire;
  assign pend2_d = (pend2_q & ~(grant & grant2))
                 | req_2 | fire;

  always_ff @(posedge clk_50 or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      timer_q <= '0;
      phase_q <= '0;
      pend1_q <= 1'b0;
      pend2_q <= 1'b0;
      last2_q <= 1'b1;
      gch2_q  <= 1'b1;
      cmd1_q  <= 1'b0;
      cmd2_q  <= 1'b0;
      busy_q  <= 1'b0;
      addr1_q <= '0;
      addr2_q <= '0;
      cnt1_q  <= '0;
      cnt2_q  <= '0;
    end else begin
      timer_q <= (tick & ~fire) ? timer_q + 32'd1 : '0;
      pend1_q <= pend1_d;
      pend2_q <= pend2_d;
      unique case (state_q)
        IDLE: begin
          if (grant) begin
            state_q <= ISSUE;
            busy_q  <= 1'b1;
            phase_q <= '0;
            last2_q <= grant2;
            gch2_q  <= grant2;
            cmd1_q  <= ~grant2;
            cmd2_q  <= grant2;
            if (grant2) addr2_q <= addr_2;
            else        addr1_q <= addr_1;
          end
        end
        ISSUE: begin
          if (!ready) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            cmd1_q  <= 1'b0;
            cmd2_q  <= 1'b0;
          end else if (phase_q == 16'(PULSE_LEN - 1)) begin
            state_q <= GAP;
            phase_q <= '0;
            cmd1_q  <= 1'b0;
            cmd2_q  <= 1'b0;
            if (gch2_q) cnt2_q <= cnt2_q + 16'd1;
            else        cnt1_q <= cnt1_q + 16'd1;
          end else begin
            phase_q <= phase_q + 16'd1;
          end
        end
        GAP: begin
          if (!ready || phase_q == 16'(GAP_LEN - 1)) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end else begin
            phase_q <= phase_q + 16'd1;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          cmd1_q  <= 1'b0;
          cmd2_q  <= 1'b0;
        end
      endcase
    end
  end

  assign start_ram_addr_1 = addr1_q;
  assign start_ram_addr_2 = addr2_q;
  assign cmd_send_1       = cmd1_q;
  assign cmd_send_2       = cmd2_q;
  assign busy             = busy_q;
  assign sent_cnt_1       = cnt1_q;
  assign sent_cnt_2       = cnt2_q;

endmodule

// File: tb/tb_packet_send_scheduler.sv
// Scoreboard bench for packet_send_scheduler with a timestamp-based
// transaction model of grants, pulses, gaps and counters.
module tb_packet_send_scheduler;

  localparam int PER = 16;
  localparam int PL  = 3;
  localparam int GL  = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        mac, rx, auto_en, req1, req2;
  logic [24:0] addr1, addr2;
  logic [24:0] sa1, sa2;
  logic        cmd1, cmd2, busy;
  logic [15:0] cnt1, cnt2;

  packet_send_scheduler #(
    .PERIOD   (32'(PER)),
    .PULSE_LEN(PL),
    .GAP_LEN  (GL)
  ) dut (
    .clk_50          (clk),
    .rst_n           (rst_n),
    .mac_inited      (mac),
    .rx_ready        (rx),
    .auto_en         (auto_en),
    .req_1           (req1),
    .req_2           (req2),
    .addr_1          (addr1),
    .addr_2          (addr2),
    .start_ram_addr_1(sa1),
    .start_ram_addr_2(sa2),
    .cmd_send_1      (cmd1),
    .cmd_send_2      (cmd2),
    .busy            (busy),
    .sent_cnt_1      (cnt1),
    .sent_cnt_2      (cnt2)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          ch;
    logic [24:0] addr;
    int          e;
  } grant_t;

  typedef struct {
    int ch;
    int len;
  } pulse_t;

  grant_t exp_g[$];
  pulse_t exp_l[$];

  int checks   = 0;
  int failures = 0;

  int          edge_n = 0;
  bit          m_p[2];
  int          m_last;
  int          m_timer;
  bit          m_occ, m_pulse, m_busy;
  int          m_gedge, m_gch;
  logic [15:0] m_cnt[2];
  bit          mon_en = 1'b0;
  int          epoch  = 0;

  task automatic chk(string nm, longint act, longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t",
               nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_p[0] = 0; m_p[1] = 0;
    m_last = 1; m_timer = 0;
    m_occ = 0; m_pulse = 0; m_busy = 0;
    m_cnt[0] = 0; m_cnt[1] = 0;
    exp_g.delete();
    exp_l.delete();
    epoch++;
  endtask

  // Applied once per rising edge with the inputs present at that edge.
  task automatic model_edge();
    bit rdy, fire;
    int ch;
    logic [24:0] a;
    edge_n++;
    rdy  = mac & rx;
    fire = 0;
    if (rdy && auto_en) begin
      if (m_timer == PER - 1) begin
        fire = 1; m_timer = 0;
      end else m_timer++;
    end else m_timer = 0;
    if (m_occ) begin
      if (!rdy) begin
        if (m_pulse) exp_l.push_back('{m_gch, edge_n - m_gedge});
        m_pulse = 0;
        m_occ   = 0;
      end else begin
        if (m_pulse && edge_n == m_gedge + PL) begin
          exp_l.push_back('{m_gch, PL});
          m_cnt[m_gch] = m_cnt[m_gch] + 16'd1;
          m_pulse = 0;
        end
        if (edge_n == m_gedge + PL + GL) m_occ = 0;
      end
    end else if (rdy && (m_p[0] || m_p[1])) begin
      if (m_p[0] && m_p[1]) ch = (m_last == 1) ? 0 : 1;
      else ch = m_p[1] ? 1 : 0;
      a = (ch == 0) ? addr1 : addr2;
      m_p[ch] = 0;
      exp_g.push_back('{ch, a, edge_n});
      m_last  = ch;
      m_gch   = ch;
      m_gedge = edge_n;
      m_occ   = 1;
      m_pulse = 1;
    end
    if (req1 || fire) m_p[0] = 1;
    if (req2 || fire) m_p[1] = 1;
    m_busy = m_occ;
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic steps(int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // Monitor: compares observed pulses against the scoreboard queues.
  bit          prev[2];
  int          hi[2];
  int          seen = 0;
  always @(negedge clk) begin
    logic        c[2];
    logic [24:0] a[2];
    grant_t      g;
    pulse_t      p;
    if (mon_en) begin
      if (seen != epoch) begin
        seen = epoch;
        prev[0] = 0; prev[1] = 0;
        hi[0] = 0; hi[1] = 0;
      end
      c[0] = cmd1; c[1] = cmd2;
      a[0] = sa1;  a[1] = sa2;
      chk("busy", busy, m_busy);
      chk("sent_cnt_1", cnt1, m_cnt[0]);
      chk("sent_cnt_2", cnt2, m_cnt[1]);
      chk("cmd_excl", cmd1 & cmd2, 0);
      for (int i = 0; i < 2; i++) begin
        if (c[i] && !prev[i]) begin
          if (exp_g.size() == 0) begin
            checks++; failures++;
            $display("FAIL unexpected_cmd ch=%0d t=%0t", i + 1, $time);
          end else begin
            g = exp_g.pop_front();
            chk("grant_ch", i, g.ch);
            chk("grant_addr", a[i], g.addr);
            chk("grant_edge", edge_n, g.e);
          end
        end
        if (!c[i] && prev[i]) begin
          if (exp_l.size() == 0) begin
            checks++; failures++;
            $display("FAIL unexpected_fall ch=%0d t=%0t", i + 1, $time);
          end else begin
            p = exp_l.pop_front();
            chk("pulse_ch", i, p.ch);
            chk("pulse_len", hi[i], p.len);
          end
          hi[i] = 0;
        end
        if (c[i]) hi[i]++;
        prev[i] = c[i];
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    mac = 0; rx = 0; auto_en = 0;
    req1 = 0; req2 = 0;
    addr1 = '0; addr2 = '0;
    model_reset();
    #2;
    chk("rst_cmd1", cmd1, 0);
    chk("rst_cmd2", cmd2, 0);
    chk("rst_busy", busy, 0);
    chk("rst_sa1", sa1, 0);
    chk("rst_sa2", sa2, 0);
    chk("rst_cnt1", cnt1, 0);
    chk("rst_cnt2", cnt2, 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n  = 1'b1;
    mon_en = 1'b1;

    // Periodic rounds.
    mac = 1; rx = 1; auto_en = 1;
    addr1 = 25'd1; addr2 = 25'd1;
    steps(70);
    auto_en = 0;
    steps(20);

    // Simultaneous manual pairs, round-robin.
    addr1 = 25'h0_1234; addr2 = 25'h1_5678;
    for (int k = 0; k < 2; k++) begin
      req1 = 1; req2 = 1;
      step();
      req1 = 0; req2 = 0;
      steps(20);
    end

    // Not ready: request held pending.
    mac = 0;
    addr1 = 25'h0_0abc;
    req1 = 1;
    step();
    req1 = 0;
    steps(6);
    mac = 1;
    steps(14);

    // Abort on the second ISSUE cycle.
    addr1 = 25'h1_ffff;
    req1 = 1;
    step();
    req1 = 0;
    step();
    step();
    rx = 0;
    step();
    rx = 1;
    steps(16);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      if (i % 200 == 0) auto_en = $urandom_range(0, 1);
      mac   = ($urandom_range(0, 99) < 96);
      rx    = ($urandom_range(0, 99) < 97);
      req1  = ($urandom_range(0, 14) == 0);
      req2  = ($urandom_range(0, 14) == 0);
      addr1 = 25'($urandom);
      addr2 = 25'($urandom);
      step();
    end
    mac = 1; rx = 1; auto_en = 0;
    req1 = 0; req2 = 0;
    steps(20);

    // Async reset mid-ISSUE.
    req1 = 1;
    step();
    req1 = 0;
    step();
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_cmd1", cmd1, 0);
    chk("arst_cmd2", cmd2, 0);
    chk("arst_busy", busy, 0);
    chk("arst_sa1", sa1, 0);
    chk("arst_cnt1", cnt1, 0);
    model_reset();
    rst_n = 1'b1;
    steps(25);
    auto_en = 1;
    steps(2 * PER + 4);
    auto_en = 0;
    steps(20);

    // Counter wrap from 16'hFFFF.
    force dut.cnt1_q = 16'hffff;
    m_cnt[0] = 16'hffff;
    #1;
    release dut.cnt1_q;
    req1 = 1;
    step();
    req1 = 0;
    steps(12);
    chk("wrap_cnt1", cnt1, 0);
    steps(5);

    chk("grants_left", exp_g.size(), 0);
    chk("pulses_left", exp_l.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
